// File: rtl/afe_ro_cfg_arbiter.sv
// Round-robin arbiter that shares the AFE configuration port between NUM_REQ requesters.
// The grant is held for a whole transaction; a watchdog aborts transfers the AFE never acknowledges.
module afe_ro_cfg_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*11-1:0]  req_addr_i,
  input  logic [NUM_REQ*32-1:0]  req_wdata_i,
  input  logic [NUM_REQ-1:0]     req_rwn_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [31:0]            req_rdata_o,
  output logic [NUM_REQ-1:0]     req_err_o,
  output logic [10:0]            cfg_addr_o,
  output logic [31:0]            cfg_wdata_o,
  output logic                   cfg_rwn_o,
  output logic                   cfg_valid_o,
  input  logic                   cfg_ready_i,
  input  logic [31:0]            cfg_rdata_i,
  output logic                   busy_o,
  output logic [NUM_REQ-1:0]     grant_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic          TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0] hi_mask_s;
  logic [NUM_REQ-1:0] pick_s;
  logic [NUM_REQ-1:0] arb_grant_s;
  logic [PW-1:0]      gidx_s;
  logic [PW-1:0]      ptr_next_s;
  logic               busy_s;
  logic               gv_s;
  logic               tmo_hit_s;
  logic               abort_s;
  logic               done_s;

  assign busy_s    = (state_q == S_BUSY);
  assign gv_s      = |(req_valid_i & grant_q);
  assign tmo_hit_s = TMO_EN & (cnt_q == CNT_LAST);
  assign abort_s   = busy_s & gv_s & tmo_hit_s;

  // Requesters at or above the pointer take priority; otherwise wrap to the lowest index.
  always_comb begin
    hi_mask_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask_s[i] = (PW'(i) >= ptr_q);
    end
    if (|(req_valid_i & hi_mask_s)) begin
      pick_s = req_valid_i & hi_mask_s;
    end else begin
      pick_s = req_valid_i;
    end
    arb_grant_s = pick_s & (~pick_s + NUM_REQ'(1));
  end

  // Encode the one-hot grant and compute the pointer used after a completion.
  always_comb begin
    gidx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        gidx_s = PW'(i);
      end else begin
        gidx_s = gidx_s;
      end
    end
    if (gidx_s == PTR_LAST) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gidx_s + PW'(1);
    end
  end

  // Route the granted requester onto the config port; all zero while no grant is held.
  always_comb begin
    cfg_addr_o  = 11'h000;
    cfg_wdata_o = 32'h0000_0000;
    cfg_rwn_o   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        cfg_addr_o  = req_addr_i[i*11 +: 11];
        cfg_wdata_o = req_wdata_i[i*32 +: 32];
        cfg_rwn_o   = req_rwn_i[i];
      end else begin
        cfg_rwn_o   = cfg_rwn_o;
      end
    end
  end

  // The abort cycle masks the request, so a late cfg_ready_i cannot complete a transfer.
  assign cfg_valid_o = busy_s & gv_s & ~tmo_hit_s;
  assign done_s      = cfg_valid_o & cfg_ready_i;
  assign req_ready_o = grant_q & {NUM_REQ{done_s | abort_s}};
  assign req_err_o   = grant_q & {NUM_REQ{abort_s}};
  assign req_rdata_o = done_s ? cfg_rdata_i : 32'h0000_0000;
  assign busy_o      = busy_s;
  assign grant_o     = grant_q;

  // Next-state logic for the IDLE/BUSY controller, pointer and watchdog counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|req_valid_i) begin
          state_d = S_BUSY;
          grant_d = arb_grant_s;
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      S_BUSY: begin
        if (done_s || abort_s) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next_s;
          cnt_d   = '0;
        end else if (!gv_s) begin
          // Requester withdrew mid-transaction: it keeps its turn.
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_afe_ro_cfg_arbiter.sv
// Directed bench for afe_ro_cfg_arbiter: one instance with the default watchdog,
// one with a 4-cycle watchdog, sharing clock, reset and data buses.
module tb_afe_ro_cfg_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  valid_a, valid_b;
  logic [21:0] addr;
  logic [63:0] wdata;
  logic [1:0]  rwn;
  logic        cfg_ready;
  logic [31:0] cfg_rdata;

  logic [1:0]  ready_a, err_a, grant_a, ready_b, err_b, grant_b;
  logic [31:0] rdata_a, rdata_b, cwdata_a, cwdata_b;
  logic [10:0] caddr_a, caddr_b;
  logic        crwn_a, crwn_b, cvalid_a, cvalid_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  afe_ro_cfg_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(256)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(valid_a), .req_addr_i(addr), .req_wdata_i(wdata), .req_rwn_i(rwn),
    .req_ready_o(ready_a), .req_rdata_o(rdata_a), .req_err_o(err_a),
    .cfg_addr_o(caddr_a), .cfg_wdata_o(cwdata_a), .cfg_rwn_o(crwn_a), .cfg_valid_o(cvalid_a),
    .cfg_ready_i(cfg_ready), .cfg_rdata_i(cfg_rdata),
    .busy_o(busy_a), .grant_o(grant_a)
  );

  afe_ro_cfg_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(valid_b), .req_addr_i(addr), .req_wdata_i(wdata), .req_rwn_i(rwn),
    .req_ready_o(ready_b), .req_rdata_o(rdata_b), .req_err_o(err_b),
    .cfg_addr_o(caddr_b), .cfg_wdata_o(cwdata_b), .cfg_rwn_o(crwn_b), .cfg_valid_o(cvalid_b),
    .cfg_ready_i(cfg_ready), .cfg_rdata_i(cfg_rdata),
    .busy_o(busy_b), .grant_o(grant_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

    rst_ni = 1'b0; valid_a = 2'b00; valid_b = 2'b00; addr = 22'h0; wdata = 64'h0;
    rwn = 2'b00; cfg_ready = 1'b0; cfg_rdata = 32'h0;
    #3;
    check_eq("rst_grant", 64'(grant_a), 64'h0);
    check_eq("rst_busy", 64'(busy_a), 64'h0);
    check_eq("rst_cvalid", 64'(cvalid_a), 64'h0);
    check_eq("rst_ready", 64'(ready_a), 64'h0);
    step;
    rst_ni = 1'b1;

    // single write from requester 0, ready 3 cycles after cfg_valid rises
    valid_a = 2'b01; addr[10:0] = 11'h123; wdata[31:0] = 32'hA5A5_0001; rwn = 2'b00;
    settle;
    check_eq("t1_idle_cvalid", 64'(cvalid_a), 64'h0);
    check_eq("t1_idle_busy", 64'(busy_a), 64'h0);
    step; settle;
    check_eq("t1_busy", 64'(busy_a), 64'h1);
    check_eq("t1_grant", 64'(grant_a), 64'h1);
    check_eq("t1_cvalid", 64'(cvalid_a), 64'h1);
    check_eq("t1_addr", 64'(caddr_a), 64'h123);
    check_eq("t1_wdata", 64'(cwdata_a), 64'hA5A5_0001);
    check_eq("t1_rwn", 64'(crwn_a), 64'h0);
    check_eq("t1_noready", 64'(ready_a), 64'h0);
    for (int k = 0; k < 2; k++) begin
      step; settle;
      check_eq("t1_wait_cvalid", 64'(cvalid_a), 64'h1);
      check_eq("t1_wait_ready", 64'(ready_a), 64'h0);
    end
    step; cfg_ready = 1'b1; settle;
    check_eq("t1_ready", 64'(ready_a), 64'h1);
    check_eq("t1_err", 64'(err_a), 64'h0);
    step; valid_a = 2'b00; cfg_ready = 1'b0; settle;
    check_eq("t1_after_busy", 64'(busy_a), 64'h0);
    check_eq("t1_after_ready", 64'(ready_a), 64'h0);

    rst_ni = 1'b0; step; rst_ni = 1'b1;

    // both requesters continuous, cfg_ready high: grants alternate
    valid_a = 2'b11; cfg_ready = 1'b1; settle;
    check_eq("t2_idle_busy", 64'(busy_a), 64'h0);
    for (int t = 0; t < 4; t++) begin
      step; settle;
      check_eq("t2_grant", 64'(grant_a), 64'(exp_g[t]));
      check_eq("t2_ready", 64'(ready_a), 64'(exp_g[t]));
      step; settle;
      check_eq("t2_gap_busy", 64'(busy_a), 64'h0);
      check_eq("t2_gap_ready", 64'(ready_a), 64'h0);
    end
    valid_a = 2'b00; cfg_ready = 1'b0;
    step; settle;
    check_eq("t2_end_busy", 64'(busy_a), 64'h0);

    // read from requester 1 at the top word address
    rwn = 2'b10; addr[21:11] = 11'h7FF; cfg_rdata = 32'hDEAD_BEEF; valid_a = 2'b10;
    settle;
    check_eq("t3_idle_rdata", 64'(rdata_a), 64'h0);
    step; settle;
    check_eq("t3_grant", 64'(grant_a), 64'h2);
    check_eq("t3_rwn", 64'(crwn_a), 64'h1);
    check_eq("t3_addr", 64'(caddr_a), 64'h7FF);
    check_eq("t3_wait_rdata", 64'(rdata_a), 64'h0);
    step; cfg_ready = 1'b1; settle;
    check_eq("t3_ready", 64'(ready_a), 64'h2);
    check_eq("t3_rdata", 64'(rdata_a), 64'hDEAD_BEEF);
    step; valid_a = 2'b00; cfg_ready = 1'b0; settle;
    check_eq("t3_after_rdata", 64'(rdata_a), 64'h0);
    check_eq("t3_after_busy", 64'(busy_a), 64'h0);

    // watchdog of 4 cycles on the second instance
    valid_b = 2'b01; settle;
    step;
    for (int k = 0; k < 3; k++) begin
      settle;
      check_eq("t4_cvalid", 64'(cvalid_b), 64'h1);
      check_eq("t4_noready", 64'(ready_b), 64'h0);
      step;
    end
    settle;
    check_eq("t4_abort_cvalid", 64'(cvalid_b), 64'h0);
    check_eq("t4_abort_ready", 64'(ready_b), 64'h1);
    check_eq("t4_abort_err", 64'(err_b), 64'h1);
    check_eq("t4_abort_rdata", 64'(rdata_b), 64'h0);
    check_eq("t4_abort_busy", 64'(busy_b), 64'h1);
    step; valid_b = 2'b11; settle;
    check_eq("t4_idle_busy", 64'(busy_b), 64'h0);
    check_eq("t4_idle_err", 64'(err_b), 64'h0);
    step; settle;
    check_eq("t4_next_grant", 64'(grant_b), 64'h2);
    cfg_ready = 1'b1; settle;
    check_eq("t4_next_ready", 64'(ready_b), 64'h2);
    check_eq("t4_next_err", 64'(err_b), 64'h0);
    check_eq("t4_next_rdata", 64'(rdata_b), 64'hDEAD_BEEF);
    step; valid_b = 2'b00; cfg_ready = 1'b0; settle;
    check_eq("t4_end_busy", 64'(busy_b), 64'h0);

    // granted requester withdraws: no completion, keeps its turn
    valid_a = 2'b01; rwn = 2'b00;
    step; settle;
    check_eq("t5_grant", 64'(grant_a), 64'h1);
    check_eq("t5_cvalid", 64'(cvalid_a), 64'h1);
    step; valid_a = 2'b00; settle;
    check_eq("t5_drop_cvalid", 64'(cvalid_a), 64'h0);
    check_eq("t5_drop_ready", 64'(ready_a), 64'h0);
    check_eq("t5_drop_busy", 64'(busy_a), 64'h1);
    step; settle;
    check_eq("t5_idle_busy", 64'(busy_a), 64'h0);
    check_eq("t5_idle_grant", 64'(grant_a), 64'h0);
    valid_a = 2'b11;
    step; settle;
    check_eq("t5_regrant", 64'(grant_a), 64'h1);
    cfg_ready = 1'b1; settle;
    check_eq("t5_ready", 64'(ready_a), 64'h1);
    step; valid_a = 2'b00; cfg_ready = 1'b0; settle;

    // reset in the middle of a transaction
    valid_a = 2'b01;
    step; settle;
    check_eq("t6_pre_busy", 64'(busy_a), 64'h1);
    rst_ni = 1'b0; #1;
    check_eq("t6_rst_cvalid", 64'(cvalid_a), 64'h0);
    check_eq("t6_rst_grant", 64'(grant_a), 64'h0);
    check_eq("t6_rst_busy", 64'(busy_a), 64'h0);
    check_eq("t6_rst_ready", 64'(ready_a), 64'h0);
    step; rst_ni = 1'b1; valid_a = 2'b11; settle;
    check_eq("t6_idle_busy", 64'(busy_a), 64'h0);
    step; settle;
    check_eq("t6_restart_grant", 64'(grant_a), 64'h1);
    cfg_ready = 1'b1; settle;
    check_eq("t6_ready", 64'(ready_a), 64'h1);
    step; valid_a = 2'b00; cfg_ready = 1'b0; settle;
    check_eq("t6_end_busy", 64'(busy_a), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
